pipelined_controller: RTL and testbench
=======================================

Name: pipelined_controller

Overview:
Next-generation decode/control unit for the ID stage. It decodes opcode/mode/S into the execute-command bundle and evaluates the ARM condition field against the NZCV flags. The bundle is registered into the ID/EX pipeline boundary with stall and flush support. A ready/valid handshake on the instruction side blocks issue while a memory access is outstanding, and a bounded wait detects memory timeouts.

Parameters:
EXE_CMD_W, 4, width of execute command field
MEM_TIMEOUT, 16, max MEM_WAIT cycles before timeout (>=1); counter width = clog2(MEM_TIMEOUT+1)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  decoded instruction fields valid
in_ready  out  1  controller accepts instruction this cycle
opcode  in  4  instruction opcode
mode  in  2  00 arith, 01 memory, 10 branch, 11 reserved
s_bit  in  1  arith: status update; memory: 1=load, 0=store
cond  in  4  ARM condition field
status  in  4  current flags {N,Z,C,V}
stall  in  1  hold ID/EX register, no accept
flush  in  1  kill ID/EX content and any pending memory wait
mem_ready  in  1  memory access completed
out_valid  out  1  registered bundle valid
exe_cmd  out  EXE_CMD_W  ALU command
wb_en  out  1  register write-back enable
mem_r_en  out  1  memory read
mem_w_en  out  1  memory write
branch  out  1  branch taken
status_en  out  1  update status register
illegal  out  1  registered, undefined opcode/mode for out_valid instruction
mem_timeout  out  1  sticky, set on memory wait timeout

Behaviour:
- Reset: all outputs 0, in_ready 0 during reset, FSM=RUN, counter=0, mem_timeout=0.
- in_ready = (state==RUN) & !stall & !flush & !reset. Accept = in_valid & in_ready.
- Decode, arith (mode 00): MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000; all these set wb_en=1 and status_en=s_bit. CMP 1010->0100 and TST 1000->0110 set status_en=1, wb_en=0. Any other opcode: NOP plus illegal=1.
- Decode, memory (mode 01): exe_cmd=0010 (address add). Load: mem_r_en=1, wb_en=1. Store: mem_w_en=1. status_en=0.
- Decode, branch (mode 10): branch=1, exe_cmd=0. Mode 11: NOP plus illegal=1.
- NOP means exe_cmd=0 and all enables 0.
- Condition codes: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1110 true, 1111 never.
- Condition fail: bundle forced to NOP, illegal still reported, out_valid=1.
- Latency: exactly 1 cycle from accept to registered outputs.
- Register update priority: reset > flush > stall > accept > bubble.
  - flush: out_valid=0, bundle=NOP, FSM->RUN, counter cleared. mem_timeout is not cleared.
  - stall: all outputs hold.
  - accept: load decoded bundle, out_valid=1.
  - otherwise: out_valid=0, bundle=NOP.
- FSM RUN->MEM_WAIT: on accept of a memory op that passes its condition. Counter cleared.
- FSM MEM_WAIT:
  - in_ready=0; output register bubbles after the issue cycle, unless stall holds it.
  - mem_ready is sampled only in MEM_WAIT; when high -> RUN next cycle.
  - Otherwise counter++. When counter==MEM_TIMEOUT-1 and mem_ready=0: mem_timeout<=1 and -> RUN.
  - A stall during MEM_WAIT does not stop the counter.
  - mem_ready high in the same cycle as flush: flush wins (-> RUN, same result).
- A condition-failed memory op stays in RUN.

Decomposition:
- Package controller_pkg: exe_cmd localparams (EXE_MOV..EXE_EOR, EXE_NOP=0), mode constants, opcode constants, cond code constants, FSM state enum {RUN, MEM_WAIT}, bundle field order.
- Sub-module cond_check (cond, status -> pass), purely combinational, instantiated once.

Test Plan:
- ADD (mode 00, opcode 0100, s=1, cond 1110), in_valid one cycle -> next cycle: out_valid=1, exe_cmd=0010, wb_en=1, status_en=1. Following cycle: out_valid=0.
- CMP, then ADD with cond EQ (0000) and status=0000 -> CMP: status_en=1, wb_en=0. ADD: out_valid=1, bundle NOP.
- Load (mode 01, s=1, AL) with mem_ready asserted 3 cycles later:
  - issue cycle: mem_r_en=1, wb_en=1, exe_cmd=0010;
  - in_ready=0 for 3 cycles, then 1;
  - mem_timeout stays 0.
- Store, mem_ready never asserted, MEM_TIMEOUT=4 -> mem_timeout=1 after 4 MEM_WAIT cycles; in_ready returns 1; mem_timeout stays 1 until reset.
- stall for 2 cycles after a MOV issue -> outputs hold exe_cmd=0001; in_ready=0. Then flush together with stall -> out_valid=0 next cycle.
- Opcode 0011 in mode 00, and mode 11 -> out_valid=1, illegal=1, all enables 0. Reset asserted mid-MEM_WAIT -> all outputs 0 next cycle, FSM=RUN.

Source files
------------

// File: rtl/pipelined_controller_pkg.sv
// Shared constants and types for the ID-stage decode/control unit:
// execute commands, opcode/mode/condition encodings, FSM states and the bundle layout.
package controller_pkg;

   localparam int CMD_W = 4;

   localparam logic [CMD_W-1:0] EXE_NOP = 4'b0000;
   localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
   localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
   localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
   localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
   localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
   localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
   localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
   localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;
   localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;

   localparam logic [1:0] MODE_ARITH  = 2'b00;
   localparam logic [1:0] MODE_MEM    = 2'b01;
   localparam logic [1:0] MODE_BRANCH = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   typedef enum logic {RUN, MEM_WAIT} state_t;

   // Field order of the ID/EX bundle, MSB first.
   typedef struct packed {
      logic [CMD_W-1:0] exe_cmd;
      logic             wb_en;
      logic             mem_r_en;
      logic             mem_w_en;
      logic             branch;
      logic             status_en;
      logic             illegal;
   } bundle_t;

endpackage

// File: rtl/pipelined_controller_cond_check.sv
// Combinational evaluation of the ARM condition field against {N,Z,C,V}.
module cond_check
   import controller_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_status,
   output logic       o_pass
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = i_status[3];
   assign w_z = i_status[2];
   assign w_c = i_status[1];
   assign w_v = i_status[0];

   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         COND_EQ: o_pass = w_z;
         COND_NE: o_pass = !w_z;
         COND_CS: o_pass = w_c;
         COND_CC: o_pass = !w_c;
         COND_MI: o_pass = w_n;
         COND_PL: o_pass = !w_n;
         COND_VS: o_pass = w_v;
         COND_VC: o_pass = !w_v;
         COND_HI: o_pass = w_c && !w_z;
         COND_LS: o_pass = !w_c || w_z;
         COND_GE: o_pass = (w_n == w_v);
         COND_LT: o_pass = (w_n != w_v);
         COND_GT: o_pass = !w_z && (w_n == w_v);
         COND_LE: o_pass = w_z || (w_n != w_v);
         COND_AL: o_pass = 1'b1;
         default: o_pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/pipelined_controller.sv
// ID-stage decode/control: decodes into the execute bundle, registers it at the
// ID/EX boundary with stall/flush, and blocks issue while a memory access is pending.
module pipelined_controller
   import controller_pkg::*;
#(
   parameter int EXE_CMD_W   = 4,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           opcode,
   input  logic [1:0]           mode,
   input  logic                 s_bit,
   input  logic [3:0]           cond,
   input  logic [3:0]           status,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 mem_ready,
   output logic                 out_valid,
   output logic [EXE_CMD_W-1:0] exe_cmd,
   output logic                 wb_en,
   output logic                 mem_r_en,
   output logic                 mem_w_en,
   output logic                 branch,
   output logic                 status_en,
   output logic                 illegal,
   output logic                 mem_timeout
);

   localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;
   logic             r_valid;
   bundle_t          r_bundle;

   logic    w_pass;
   logic    w_in_ready;
   logic    w_accept;
   logic    w_mem_issue;
   bundle_t w_dec;
   bundle_t w_bundle;

   cond_check u_cond_check (
      .i_cond   (cond),
      .i_status (status),
      .o_pass   (w_pass)
   );

   always_comb begin
      w_dec = '0;
      case (mode)
         MODE_ARITH: begin
            case (opcode)
               OP_MOV: begin w_dec.exe_cmd = EXE_MOV; w_dec.wb_en = 1'b1; w_dec.status_en = s_bit; end
               OP_MVN: begin w_dec.exe_cmd = EXE_MVN; w_dec.wb_en = 1'b1; w_dec.status_en = s_bit; end
               OP_ADD: begin w_dec.exe_cmd = EXE_ADD; w_dec.wb_en = 1'b1; w_dec.status_en = s_bit; end
               OP_ADC: begin w_dec.exe_cmd = EXE_ADC; w_dec.wb_en = 1'b1; w_dec.status_en = s_bit; end
               OP_SUB: begin w_dec.exe_cmd = EXE_SUB; w_dec.wb_en = 1'b1; w_dec.status_en = s_bit; end
               OP_SBC: begin w_dec.exe_cmd = EXE_SBC; w_dec.wb_en = 1'b1; w_dec.status_en = s_bit; end
               OP_AND: begin w_dec.exe_cmd = EXE_AND; w_dec.wb_en = 1'b1; w_dec.status_en = s_bit; end
               OP_ORR: begin w_dec.exe_cmd = EXE_ORR; w_dec.wb_en = 1'b1; w_dec.status_en = s_bit; end
               OP_EOR: begin w_dec.exe_cmd = EXE_EOR; w_dec.wb_en = 1'b1; w_dec.status_en = s_bit; end
               // Compare/test only update flags; no register result.
               OP_CMP: begin w_dec.exe_cmd = EXE_SUB; w_dec.status_en = 1'b1; end
               OP_TST: begin w_dec.exe_cmd = EXE_AND; w_dec.status_en = 1'b1; end
               default: w_dec.illegal = 1'b1;
            endcase
         end
         MODE_MEM: begin
            w_dec.exe_cmd  = EXE_ADD;
            w_dec.mem_r_en = s_bit;
            w_dec.wb_en    = s_bit;
            w_dec.mem_w_en = !s_bit;
         end
         MODE_BRANCH: w_dec.branch = 1'b1;
         default:     w_dec.illegal = 1'b1;
      endcase
   end

   // A failed condition squashes every effect but still reports an undefined encoding.
   always_comb begin
      w_bundle         = '0;
      w_bundle.illegal = w_dec.illegal;
      if (w_pass) w_bundle = w_dec;
   end

   assign w_in_ready  = (r_state == RUN) && !stall && !flush && !reset;
   assign w_accept    = in_valid && w_in_ready;
   assign w_mem_issue = w_accept && (mode == MODE_MEM) && w_pass;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= RUN;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
         r_valid   <= 1'b0;
         r_bundle  <= '0;
      end else if (flush) begin
         r_state  <= RUN;
         r_cnt    <= '0;
         r_valid  <= 1'b0;
         r_bundle <= '0;
      end else begin
         if (!stall) begin
            r_valid  <= w_accept;
            r_bundle <= w_accept ? w_bundle : '0;
         end
         // The wait counter keeps running through stalls.
         case (r_state)
            RUN: begin
               if (w_mem_issue) begin
                  r_state <= MEM_WAIT;
                  r_cnt   <= '0;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  r_state <= RUN;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= RUN;
                  r_cnt     <= '0;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = r_valid;
   assign exe_cmd     = EXE_CMD_W'(r_bundle.exe_cmd);
   assign wb_en       = r_bundle.wb_en;
   assign mem_r_en    = r_bundle.mem_r_en;
   assign mem_w_en    = r_bundle.mem_w_en;
   assign branch      = r_bundle.branch;
   assign status_en   = r_bundle.status_en;
   assign illegal     = r_bundle.illegal;
   assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench for pipelined_controller with MEM_TIMEOUT=4; expected values hand-computed.
module tb_pipelined_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] opcode;
   logic [1:0] mode;
   logic       s_bit;
   logic [3:0] cond;
   logic [3:0] status;
   logic       stall;
   logic       flush;
   logic       mem_ready;
   logic       out_valid;
   logic [3:0] exe_cmd;
   logic       wb_en;
   logic       mem_r_en;
   logic       mem_w_en;
   logic       branch;
   logic       status_en;
   logic       illegal;
   logic       mem_timeout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   pipelined_controller #(.EXE_CMD_W(4), .MEM_TIMEOUT(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode      (opcode),
      .mode        (mode),
      .s_bit       (s_bit),
      .cond        (cond),
      .status      (status),
      .stall       (stall),
      .flush       (flush),
      .mem_ready   (mem_ready),
      .out_valid   (out_valid),
      .exe_cmd     (exe_cmd),
      .wb_en       (wb_en),
      .mem_r_en    (mem_r_en),
      .mem_w_en    (mem_w_en),
      .branch      (branch),
      .status_en   (status_en),
      .illegal     (illegal),
      .mem_timeout (mem_timeout)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Packed as {out_valid, exe_cmd, wb_en, mem_r_en, mem_w_en, branch, status_en, illegal}.
   task automatic chk_out(input string tag, input logic v, input logic [3:0] cmd,
                          input logic wb, input logic r, input logic w,
                          input logic br, input logic st, input logic il);
      chk(tag, 16'({out_valid, exe_cmd, wb_en, mem_r_en, mem_w_en, branch, status_en, illegal}),
               16'({v, cmd, wb, r, w, br, st, il}));
   endtask

   task automatic set_instr(input logic [1:0] m, input logic [3:0] op, input logic s,
                            input logic [3:0] c);
      in_valid = 1'b1;
      mode     = m;
      opcode   = op;
      s_bit    = s;
      cond     = c;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; opcode = 4'h0; mode = 2'b00; s_bit = 1'b0;
      cond = 4'hE; status = 4'h0; stall = 1'b0; flush = 1'b0; mem_ready = 1'b0;
      tick();
      tick();
      chk_out("reset_bundle", 0, 4'h0, 0, 0, 0, 0, 0, 0);
      chk("reset_in_ready", 16'(in_ready), 16'h0);
      chk("reset_timeout", 16'(mem_timeout), 16'h0);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", 16'(in_ready), 16'h1);

      // ADD s=1 AL
      set_instr(2'b00, 4'b0100, 1'b1, 4'b1110);
      tick();
      in_valid = 1'b0;
      chk_out("add", 1, 4'b0010, 1, 0, 0, 0, 1, 0);
      tick();
      chk_out("add_bubble", 0, 4'h0, 0, 0, 0, 0, 0, 0);

      // CMP then ADD EQ with Z=0 (fails)
      status = 4'b0000;
      set_instr(2'b00, 4'b1010, 1'b0, 4'b1110);
      tick();
      chk_out("cmp", 1, 4'b0100, 0, 0, 0, 0, 1, 0);
      set_instr(2'b00, 4'b0100, 1'b1, 4'b0000);
      tick();
      chk_out("add_eq_fail", 1, 4'h0, 0, 0, 0, 0, 0, 0);
      // SUB GT with N=V=Z=0 passes; s=0 -> no status update
      set_instr(2'b00, 4'b0010, 1'b0, 4'b1100);
      tick();
      chk_out("sub_gt_pass", 1, 4'b0100, 1, 0, 0, 0, 0, 0);
      // Branch LT with N=1,V=0 taken
      status = 4'b1000;
      set_instr(2'b10, 4'b0000, 1'b0, 4'b1011);
      tick();
      chk_out("branch_lt", 1, 4'h0, 0, 0, 0, 1, 0, 0);
      // Branch HI with C=0 not taken
      set_instr(2'b10, 4'b0000, 1'b0, 4'b1000);
      tick();
      chk_out("branch_hi_fail", 1, 4'h0, 0, 0, 0, 0, 0, 0);
      // TST s=0 AL; EOR s=1 AL
      set_instr(2'b00, 4'b1000, 1'b0, 4'b1110);
      tick();
      chk_out("tst", 1, 4'b0110, 0, 0, 0, 0, 1, 0);
      set_instr(2'b00, 4'b0001, 1'b1, 4'b1110);
      tick();
      in_valid = 1'b0;
      chk_out("eor", 1, 4'b1000, 1, 0, 0, 0, 1, 0);
      tick();

      // Load, mem_ready in the third wait cycle
      set_instr(2'b01, 4'b0000, 1'b1, 4'b1110);
      tick();
      in_valid = 1'b0;
      chk_out("load_issue", 1, 4'b0010, 1, 1, 0, 0, 0, 0);
      chk("load_wait1_ready", 16'(in_ready), 16'h0);
      tick();
      chk_out("load_bubble", 0, 4'h0, 0, 0, 0, 0, 0, 0);
      chk("load_wait2_ready", 16'(in_ready), 16'h0);
      tick();
      chk("load_wait3_ready", 16'(in_ready), 16'h0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("load_done_ready", 16'(in_ready), 16'h1);
      chk("load_no_timeout", 16'(mem_timeout), 16'h0);

      // Store with no mem_ready: times out after 4 wait cycles
      set_instr(2'b01, 4'b0000, 1'b0, 4'b1110);
      tick();
      in_valid = 1'b0;
      chk_out("store_issue", 1, 4'b0010, 0, 0, 1, 0, 0, 0);
      chk("store_wait_ready", 16'(in_ready), 16'h0);
      tick();
      chk("store_to_1", 16'(mem_timeout), 16'h0);
      tick();
      chk("store_to_2", 16'(mem_timeout), 16'h0);
      chk("store_wait3_ready", 16'(in_ready), 16'h0);
      tick();
      chk("store_to_3", 16'(mem_timeout), 16'h0);
      chk("store_wait4_ready", 16'(in_ready), 16'h0);
      tick();
      chk("store_timeout", 16'(mem_timeout), 16'h1);
      chk("store_ready_back", 16'(in_ready), 16'h1);
      tick();
      tick();
      chk("timeout_sticky", 16'(mem_timeout), 16'h1);

      // MOV then stall two cycles, then flush together with stall
      set_instr(2'b00, 4'b1101, 1'b0, 4'b1110);
      tick();
      chk_out("mov", 1, 4'b0001, 1, 0, 0, 0, 0, 0);
      set_instr(2'b00, 4'b0100, 1'b1, 4'b1110);
      stall = 1'b1;
      #1;
      chk("stall_in_ready", 16'(in_ready), 16'h0);
      tick();
      chk_out("stall_hold1", 1, 4'b0001, 1, 0, 0, 0, 0, 0);
      tick();
      chk_out("stall_hold2", 1, 4'b0001, 1, 0, 0, 0, 0, 0);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", 16'(in_ready), 16'h0);
      tick();
      stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
      chk_out("flush_kill", 0, 4'h0, 0, 0, 0, 0, 0, 0);
      chk("flush_keeps_timeout", 16'(mem_timeout), 16'h1);

      // Illegal encodings
      set_instr(2'b00, 4'b0011, 1'b1, 4'b1110);
      tick();
      chk_out("illegal_op", 1, 4'h0, 0, 0, 0, 0, 0, 1);
      set_instr(2'b11, 4'b0100, 1'b1, 4'b1110);
      tick();
      chk_out("illegal_mode", 1, 4'h0, 0, 0, 0, 0, 0, 1);
      set_instr(2'b11, 4'b0100, 1'b1, 4'b1111);
      tick();
      chk_out("illegal_cond_nv", 1, 4'h0, 0, 0, 0, 0, 0, 1);
      // Condition-failed store stays in RUN
      set_instr(2'b01, 4'b0000, 1'b0, 4'b1111);
      tick();
      in_valid = 1'b0;
      chk_out("store_nv", 1, 4'h0, 0, 0, 0, 0, 0, 0);
      chk("store_nv_ready", 16'(in_ready), 16'h1);

      // Flush with mem_ready during MEM_WAIT
      set_instr(2'b01, 4'b0000, 1'b0, 4'b1110);
      tick();
      in_valid = 1'b0;
      chk("flushwait_ready0", 16'(in_ready), 16'h0);
      flush = 1'b1; mem_ready = 1'b1;
      tick();
      flush = 1'b0; mem_ready = 1'b0;
      #1;
      chk("flushwait_ready1", 16'(in_ready), 16'h1);
      chk_out("flushwait_out", 0, 4'h0, 0, 0, 0, 0, 0, 0);

      // Reset in the middle of MEM_WAIT
      set_instr(2'b01, 4'b0000, 1'b1, 4'b1110);
      tick();
      in_valid = 1'b0;
      tick();
      chk("rstwait_ready0", 16'(in_ready), 16'h0);
      reset = 1'b1;
      tick();
      chk_out("rstwait_out", 0, 4'h0, 0, 0, 0, 0, 0, 0);
      chk("rstwait_timeout", 16'(mem_timeout), 16'h0);
      reset = 1'b0;
      #1;
      chk("rstwait_run", 16'(in_ready), 16'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
